// File: rtl/ram_bus_pkg.sv
// Shared types and widths for the RAM bus controller.
// Imported by ram_bus_ctrl and byte_merge.
package ram_bus_pkg;
  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } state_t;
endpackage

// File: rtl/ram_bus_ctrl_byte_merge.sv
// Per-lane merge of new write data over the current RAM word.
// Used for read-modify-write of partial-byte writes.
module byte_merge
  import ram_bus_pkg::*;
(
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (i_be[i]) o_data[8*i +: 8] = i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ram_bus_ctrl.sv
// Single-outstanding request/response bridge onto a 1-cycle RAM.
// Define RAM_BUS_CTRL_BOUNDS_CHECK_EN to flag out-of-range accesses.
module ram_bus_ctrl
  import ram_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [29:0]         r_word;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   w_merged;
  logic                w_oob;
  logic                w_unused;

`ifdef RAM_BUS_CTRL_BOUNDS_CHECK_EN
  assign w_oob    = (r_word >= 30'(DEPTH));
  assign w_unused = &{1'b0, req_addr[1:0]};
`else
  // Upper word bits are dropped, so addresses wrap modulo DEPTH.
  assign w_oob    = 1'b0;
  assign w_unused = &{1'b0, req_addr[1:0], r_word[29:AW]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      if (req_valid && req_ready) begin
        r_we    <= req_we;
        r_word  <= req_addr[31:2];
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
    end
  end

  byte_merge u_merge (
    .i_wdata (r_wdata),
    .i_rdata (ram_dout),
    .i_be    (r_be),
    .o_data  (w_merged)
  );

  always_comb begin
    w_next = r_state;
    ram_en = 1'b0;
    ram_we = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid) w_next = ACCESS;
      end
      ACCESS: begin
        w_next = RESP;
        if (w_oob) begin
          ram_en = 1'b0;
        end else if (!r_we) begin
          ram_en = 1'b1;
        end else if (r_be == '1) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
        end else if (r_be != '0) begin
          // Partial write: fetch the old word first.
          ram_en = 1'b1;
          w_next = MERGE;
        end
      end
      MERGE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        w_next = RESP;
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign ram_addr  = r_word[AW-1:0];
  assign ram_di    = (r_state == MERGE) ? w_merged : r_wdata;
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = rsp_valid && w_oob;
  // RAM is idle in RESP, so ram_dout holds the read word.
  assign rsp_rdata = (rsp_valid && !r_we && !w_oob) ? ram_dout : '0;

endmodule

// File: doc/ram_bus_ctrl.md
RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 Parameter: DEPTH, 1024, RAM depth in 32-bit words.
REQ-002 Parameter: AW, $clog2(DEPTH), RAM word-address width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted when high with req_valid.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 req_wdata  in  32  write data.
REQ-010 req_be  in  4  byte enables, bit i = byte lane i.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  out-of-range access flag.
REQ-015 ram_en, ram_we  out  1 each  RAM enable and write enable.
REQ-016 ram_addr  out  AW  RAM word address.
REQ-017 ram_di  out  32  RAM write data.
REQ-018 ram_dout  in  32  RAM read data, valid one edge after a read, held while ram_en=0.

Function
REQ-019 States: IDLE, ACCESS, MERGE, RESP; one outstanding transaction only.
REQ-020 req_ready SHALL be 1 only in IDLE; acceptance (cycle T0) latches we/addr/wdata/be and enters ACCESS.
REQ-021 ACCESS (T1), read: ram_en=1, ram_we=0 -> RESP; rsp_valid at T2 with rsp_rdata=ram_dout.
REQ-022 ACCESS, write with be=4'b1111: ram_en=1, ram_we=1, ram_di=wdata -> RESP; rsp_valid at T2.
REQ-023 ACCESS, write with partial be: ram_en=1, ram_we=0 -> MERGE; MERGE (T2): ram_en=1, ram_we=1, ram_di = per-lane mux (be ? wdata : ram_dout) -> RESP; rsp_valid at T3.
REQ-024 ACCESS, write with be=4'b0000: ram_en=0 (no RAM access) -> RESP; rsp_valid at T2.
REQ-025 RESP: ram_en=0, so ram_dout stays stable; rsp_valid, rsp_rdata and rsp_err are held until rsp_ready=1, then -> IDLE.
REQ-026 req_ready returns high in the cycle after the response handshake; no request is accepted in the same cycle as a response.
REQ-027 ram_* outputs are combinational from state and latched request; ram_en=0 in IDLE and RESP.
REQ-028 ram_addr = latched req_addr[AW+1:2].

Reset
REQ-029 While rst=1: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, ram_en=0, ram_we=0, and latched request registers are cleared to 0.
REQ-030 Reset asserted mid-transaction drops the transaction; a pending MERGE write is not performed.

Configuration
REQ-031 Macro RAM_BUS_CTRL_BOUNDS_CHECK_EN defined: an access with req_addr[31:2] >= DEPTH performs no RAM access (ram_en=0 in ACCESS), goes to RESP at T2 with rsp_err=1 and rsp_rdata=0.
REQ-032 Macro not defined: the upper address bits are ignored, so accesses wrap modulo DEPTH, and rsp_err is tied to 0.

Structure
REQ-033 Package ram_bus_pkg: state enum (IDLE/ACCESS/MERGE/RESP), BE_W=4, DATA_W=32.
REQ-034 Sub-module byte_merge: combinational per-lane merge of wdata and ram_dout under be.

Verification (bench with a 1024-word RAM model, one-cycle read latency, output held while disabled)
REQ-035 Write 0xDEADBEEF at addr 0x10 with be=1111, then read addr 0x10 -> rsp_valid 2 cycles after each acceptance; read rsp_rdata=0xDEADBEEF.
REQ-036 Word preloaded 0x11223344 at addr 0x20; write 0xAABBCCDD with be=0101 -> RAM reads at T1 and writes at T2; a subsequent read returns 0x11BB33DD.
REQ-037 Read with rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable; req_ready=0 throughout; ram_en=0 throughout.
REQ-038 Write with be=0000 -> ram_en never asserted; rsp_valid at T2; memory is unchanged.
REQ-039 Assert rst during MERGE -> ram_we is never asserted; rsp_valid=0 immediately; memory is unchanged; req_ready=1 after release.
REQ-040 Read addr 0x1000 (word 1024) -> with macro: rsp_err=1, rsp_rdata=0, no RAM access; without macro: returns the contents of word 0.
